// File: rtl/risc_mem_pkg.sv
// Shared definitions for the data-memory access path: FSM encoding, access modes, memory size.
package risc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic MODE_WORD = 1'b0;
    localparam logic MODE_BYTE = 1'b1;

    localparam int MEM_BYTES_DEF = 2048;

endpackage

// File: rtl/mem_data_align.sv
// Combinational load-data byte select/extension and store-data formatting.
// Words are big-endian, so a byte load takes the high byte of the returned word.
module mem_data_align
    import risc_mem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              ld_mode,
    input  logic              ld_signed,
    input  logic [DATA_W-1:0] ld_raw,
    output logic [DATA_W-1:0] ld_data,
    input  logic              st_mode,
    input  logic [DATA_W-1:0] st_raw,
    output logic [DATA_W-1:0] st_data
);

    logic [7:0]        byte_hi;
    logic              ext_bit;
    logic [DATA_W-1:0] byte_ext;

    assign byte_hi = ld_raw[DATA_W-1 -: 8];
    assign ext_bit = ld_signed & byte_hi[7];
    assign byte_ext[7:0] = byte_hi;

    genvar gi;
    generate
        for (gi = 8; gi < DATA_W; gi++) begin : g_ext
            assign byte_ext[gi] = ext_bit;
        end
    endgenerate

    assign ld_data = (ld_mode == MODE_BYTE) ? byte_ext : ld_raw;
    assign st_data = (st_mode == MODE_BYTE) ? {{(DATA_W-8){1'b0}}, st_raw[7:0]} : st_raw;

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: request latch, range check and IDLE/ISSUE/RESP handshake FSM.
// Optional macro ALIGN_CHECK_EN additionally rejects word accesses at odd addresses.
module mem_access_unit
    import risc_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_rd,
    output logic              mem_wn,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_mode,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic              mode_q, mode_d;
    logic              signed_q, signed_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wn_q, mem_wn_d;
    logic              mem_mode_q, mem_mode_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;

    logic              req_mode;
    logic              accept;
    logic              legal;
    logic [31:0]       addr_ext;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_data;

    assign req_mode = req_byte ? MODE_BYTE : MODE_WORD;
    assign addr_ext = 32'(req_addr);

    // Upper bound depends on access width so a word never straddles the top of memory.
`ifdef ALIGN_CHECK_EN
    assign legal = req_byte ? (addr_ext <= 32'(MEM_BYTES - 1))
                            : ((addr_ext <= 32'(MEM_BYTES - 2)) && !req_addr[0]);
`else
    assign legal = req_byte ? (addr_ext <= 32'(MEM_BYTES - 1))
                            : (addr_ext <= 32'(MEM_BYTES - 2));
`endif

    assign req_ready = rst_n && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
    assign accept    = req_valid && req_ready;

    mem_data_align #(.DATA_W(DATA_W)) u_align (
        .ld_mode   (mode_q),
        .ld_signed (signed_q),
        .ld_raw    (mem_read_data),
        .ld_data   (load_data),
        .st_mode   (req_mode),
        .st_raw    (req_wdata),
        .st_data   (store_data)
    );

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        mode_d           = mode_q;
        signed_d         = signed_q;
        resp_valid_d     = resp_valid_q;
        resp_err_d       = resp_err_q;
        resp_rdata_d     = resp_rdata_q;
        mem_rd_d         = 1'b0;
        mem_wn_d         = 1'b0;
        mem_mode_d       = 1'b0;
        mem_address_d    = '0;
        mem_write_data_d = '0;

        case (state_q)
            ISSUE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = write_q ? '0 : load_data;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new request overrides the IDLE/RESP defaults above.
        if (accept) begin
            write_d  = req_write;
            mode_d   = req_mode;
            signed_d = req_signed;
            if (legal) begin
                state_d          = ISSUE;
                resp_valid_d     = 1'b0;
                resp_err_d       = 1'b0;
                resp_rdata_d     = '0;
                mem_rd_d         = !req_write;
                mem_wn_d         = req_write;
                mem_mode_d       = req_mode;
                mem_address_d    = req_addr;
                mem_write_data_d = req_write ? store_data : '0;
            end else begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            mode_q           <= MODE_WORD;
            signed_q         <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= '0;
            mem_rd_q         <= 1'b0;
            mem_wn_q         <= 1'b0;
            mem_mode_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            mode_q           <= mode_d;
            signed_q         <= signed_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_rd_q         <= mem_rd_d;
            mem_wn_q         <= mem_wn_d;
            mem_mode_q       <= mem_mode_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_rd         = mem_rd_q;
    assign mem_wn         = mem_wn_q;
    assign mem_mode       = mem_mode_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 2 KiB big-endian data memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_write, req_byte, req_signed;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [15:0] resp_rdata;
    logic        mem_rd, mem_wn, mem_mode;
    logic [15:0] mem_address, mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_byte       (req_byte),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_rd         (mem_rd),
        .mem_wn         (mem_wn),
        .mem_address    (mem_address),
        .mem_mode       (mem_mode),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Behavioural data memory: combinational read, negedge write.
    logic [7:0] mem [0:2047];
    int         rd_a;

    always_comb begin
        rd_a          = int'(mem_address);
        mem_read_data = 16'h0000;
        if (mem_rd && !mem_wn) begin
            if (rd_a < 2048)     mem_read_data[15:8] = mem[rd_a];
            if (rd_a + 1 < 2048) mem_read_data[7:0]  = mem[rd_a + 1];
        end
    end

    always @(negedge clk) begin
        if (mem_wn) begin
            if (mem_mode) begin
                mem[int'(mem_address)] <= mem_write_data[7:0];
            end else begin
                mem[int'(mem_address)]     <= mem_write_data[15:8];
                mem[int'(mem_address) + 1] <= mem_write_data[7:0];
            end
        end
    end

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int wn_cnt = 0;
    int rd_cnt = 0;
    int overlap_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wn) wn_cnt <= wn_cnt + 1;
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_rd && mem_wn) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          acc_cyc;
        bit          chk_lat;
        string       name;
    } exp_t;

    exp_t sb[$];

    // Monitor: a response is consumed on the posedge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b, expected no response",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("resp %s: rdata=%h err=%b", e.name, resp_rdata, resp_err);
                check({e.name, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
                check({e.name, "_err"}, 64'(resp_err), 64'(e.err));
                // Legal: handshake completes at edge acc+2; error: at edge acc+1.
                if (e.chk_lat)
                    check({e.name, "_latency"}, 64'(cyc - e.acc_cyc), e.err ? 64'd0 : 64'd1);
            end
        end
    end

    // Starts at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic do_req(input bit wr, input bit byt, input bit sgn,
                          input logic [15:0] addr, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input bit exp_err,
                          input bit chk_lat, input string name, output int waits);
        exp_t e;
        req_valid  = 1'b1;
        req_write  = wr;
        req_byte   = byt;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            checks++;
            $display("FAIL %s_accept_timeout: req_ready=0 after %0d cycles, expected 1", name, waits);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.rdata   = exp_rd;
        e.err     = exp_err;
        e.acc_cyc = cyc;
        e.chk_lat = chk_lat;
        e.name    = name;
        sb.push_back(e);
        $display("req  %s: wr=%b byte=%b signed=%b addr=%h wdata=%h", name, wr, byt, sgn, addr, wd);
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int wn0, rd0, w;
        for (int i = 0; i < 2048; i++) mem[i] = (i < 16) ? 8'(i + 1) : 8'hA5;
        req_valid = 0; req_write = 0; req_byte = 0; req_signed = 0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

        #2;
        check("reset_outputs",
              64'({req_ready, resp_valid, resp_err, resp_rdata, mem_rd, mem_wn, mem_mode,
                   mem_address, mem_write_data}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        do_req(0, 0, 0, 16'h0000, 16'h0000, 16'h0102, 0, 1, "ld_word_0", waits);
        do_req(0, 1, 0, 16'h0003, 16'h0000, 16'h0004, 0, 1, "ld_byte_3_u", waits);
        do_req(1, 1, 0, 16'h0005, 16'h1280, 16'h0000, 0, 1, "st_byte_5", waits);
        do_req(0, 1, 1, 16'h0005, 16'h0000, 16'hFF80, 0, 1, "ld_byte_5_s", waits);
        wait_drain();

        wn0 = wn_cnt; rd0 = rd_cnt;
        do_req(1, 0, 0, 16'h0010, 16'hBEEF, 16'h0000, 0, 1, "st_word_10", waits);
        wait_drain();
        check("st_word_wn_cycles", 64'(wn_cnt - wn0), 64'd1);
        check("st_word_rd_cycles", 64'(rd_cnt - rd0), 64'd0);
        do_req(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1, "ld_word_10", waits);
        wait_drain();

        wn0 = wn_cnt; rd0 = rd_cnt;
        do_req(0, 0, 0, 16'h07FF, 16'h0000, 16'h0000, 1, 1, "ld_word_7ff_err", waits);
        do_req(0, 1, 0, 16'h0800, 16'h0000, 16'h0000, 1, 1, "ld_byte_800_err", waits);
        do_req(1, 0, 0, 16'hFFFF, 16'h5555, 16'h0000, 1, 1, "st_word_ffff_err", waits);
        wait_drain();
        check("err_wn_cycles", 64'(wn_cnt - wn0), 64'd0);
        check("err_rd_cycles", 64'(rd_cnt - rd0), 64'd0);
        check("err_store_untouched", 64'(mem[2047]), 64'h00A5);

        do_req(0, 1, 0, 16'h07FF, 16'h0000, 16'h00A5, 0, 1, "ld_byte_7ff", waits);
`ifdef ALIGN_CHECK_EN
        do_req(0, 0, 0, 16'h0001, 16'h0000, 16'h0000, 1, 1, "ld_word_1_misaligned", waits);
`else
        do_req(0, 0, 0, 16'h0001, 16'h0000, 16'h0203, 0, 1, "ld_word_1_odd", waits);
`endif
        wait_drain();

        // Back-pressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        do_req(0, 0, 0, 16'h0000, 16'h0000, 16'h0102, 0, 0, "ld_word_0_held", waits);
        w = 0;
        @(negedge clk);
        while (!resp_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        for (int k = 0; k < 3; k++) begin
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_rdata", 64'(resp_rdata), 64'h0102);
            check("hold_err", 64'(resp_err), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        do_req(0, 1, 0, 16'h0003, 16'h0000, 16'h0004, 0, 1, "ld_byte_3_b2b", waits);
        check("b2b_same_cycle_accept", 64'(waits), 64'd0);
        wait_drain();

        // Reset while a store is in ISSUE, before the mid-cycle negedge.
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 16'h0020; req_wdata = 16'h1234;
        @(negedge clk);
        check("rst_store_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        $display("req  st_word_20_reset: wr=1 byte=0 addr=0020 wdata=1234");
        check("rst_store_in_issue", 64'(mem_wn), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              64'({req_ready, resp_valid, resp_err, resp_rdata, mem_rd, mem_wn, mem_mode,
                   mem_address, mem_write_data}), 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        check("rst_store_lost", 64'({mem[32], mem[33]}), 64'hA5A5);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_state", 64'({req_ready, resp_valid}), 64'b10);
        @(posedge clk); #1;
        do_req(0, 0, 0, 16'h0020, 16'h0000, 16'hA5A5, 0, 1, "ld_word_20", waits);
        wait_drain();

        check("rd_wn_never_together", 64'(overlap_cnt), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
